// File: rtl/vxe_cu_cmd_dispatch.sv
// vxe_cu_cmd_dispatch: CU command sequencer between the command decoder and
// the VPU array. It dispatches VPU commands as a unicast or a broadcast,
// executes SYNC barriers and parks the CU in ERR when a decode error is seen.
// Optional macro VXE_CU_DISP_PERF_EN enables the dispatch and stall counters.
// When the macro is undefined, both counter outputs are tied to zero.
module vxe_cu_cmd_dispatch #(
  parameter int VPUS_NR = 2
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_start,
  input  logic               i_vld,
  output logic               o_rdy,
  input  logic               i_dec_err,
  input  logic               i_cu_cmd,
  input  logic               i_cu_sync,
  input  logic               i_cu_sync_stop,
  input  logic               i_cu_sync_intr,
  input  logic               i_vpu_cmd,
  input  logic [VPUS_NR-1:0] i_vpu_mask,
  input  logic [4:0]         i_vpu_op,
  input  logic [2:0]         i_vpu_th,
  input  logic [47:0]        i_vpu_pl,
  output logic [VPUS_NR-1:0] o_vpu_vld,
  input  logic [VPUS_NR-1:0] i_vpu_rdy,
  output logic [4:0]         o_vpu_op,
  output logic [2:0]         o_vpu_th,
  output logic [47:0]        o_vpu_pl,
  input  logic [VPUS_NR-1:0] i_vpu_busy,
  output logic               o_stopped,
  output logic               o_err,
  output logic               o_intr,
  output logic [31:0]        o_perf_cmds,
  output logic [31:0]        o_perf_stall
);

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_DISP = 3'd1,
    S_SYNC = 3'd2,
    S_STOP = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t             r_state;
  logic [VPUS_NR-1:0] r_pend;
  logic [4:0]         r_op;
  logic [2:0]         r_th;
  logic [47:0]        r_pl;
  logic               r_sync_stop;
  logic               r_sync_intr;
  logic               r_intr;

  // pending VPUs that are still missing their ready after this cycle
  logic [VPUS_NR-1:0] w_pend_nxt;
  logic               w_all_idle;

  assign w_pend_nxt = r_pend & ~i_vpu_rdy;
  assign w_all_idle = ~|i_vpu_busy;

  // all status outputs are decoded from the state register; o_rdy must not see i_vld
  assign o_rdy     = (r_state == S_RUN);
  assign o_stopped = (r_state == S_STOP);
  assign o_err     = (r_state == S_ERR);
  assign o_intr    = r_intr;
  assign o_vpu_vld = r_pend;
  assign o_vpu_op  = r_op;
  assign o_vpu_th  = r_th;
  assign o_vpu_pl  = r_pl;

  // sequencer FSM; r_pend is non-zero only while in DISP
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_STOP;
      r_pend      <= '0;
      r_op        <= '0;
      r_th        <= '0;
      r_pl        <= '0;
      r_sync_stop <= 1'b0;
      r_sync_intr <= 1'b0;
      r_intr      <= 1'b0;
    end else begin
      r_intr <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (i_vld) begin
            // decode error wins over every other field; CU class wins over VPU class
            if (i_dec_err) begin
              r_state <= S_ERR;
            end else if (i_cu_cmd) begin
              if (i_cu_sync) begin
                r_sync_stop <= i_cu_sync_stop;
                r_sync_intr <= i_cu_sync_intr;
                r_state     <= S_SYNC;
              end
            end else if (i_vpu_cmd) begin
              if (i_vpu_mask == '0) begin
                r_state <= S_ERR;
              end else begin
                r_op    <= i_vpu_op;
                r_th    <= i_vpu_th;
                r_pl    <= i_vpu_pl;
                r_pend  <= i_vpu_mask;
                r_state <= S_DISP;
              end
            end
          end
        end
        S_DISP: begin
          r_pend <= w_pend_nxt;
          if (w_pend_nxt == '0) r_state <= S_RUN;
        end
        S_SYNC: begin
          if (w_all_idle) begin
            r_intr  <= r_sync_intr;
            r_state <= r_sync_stop ? S_STOP : S_RUN;
          end
        end
        S_STOP, S_ERR: begin
          if (i_start) r_state <= S_RUN;
        end
        default: r_state <= S_STOP;
      endcase
    end
  end

`ifdef VXE_CU_DISP_PERF_EN
  logic [31:0] r_perf_cmds;
  logic [31:0] r_perf_stall;
  logic        w_disp_done;
  logic        w_stall;

  assign w_disp_done = (r_state == S_DISP) && (w_pend_nxt == '0);
  assign w_stall     = ((r_state == S_DISP) && (w_pend_nxt != '0)) ||
                       ((r_state == S_SYNC) && !w_all_idle);

  // free-running wrap-around counters, cleared by any start pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_perf_cmds  <= '0;
      r_perf_stall <= '0;
    end else if (i_start) begin
      r_perf_cmds  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_disp_done) r_perf_cmds  <= r_perf_cmds + 32'd1;
      if (w_stall)     r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_cmds  = r_perf_cmds;
  assign o_perf_stall = r_perf_stall;
`else
  assign o_perf_cmds  = '0;
  assign o_perf_stall = '0;
`endif

endmodule

// File: tb/tb_vxe_cu_cmd_dispatch.sv
// Directed table-driven bench for vxe_cu_cmd_dispatch (VPUS_NR=2).
// Each vector drives one cycle of inputs and checks the outputs seen in that cycle.
module tb_vxe_cu_cmd_dispatch;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        i_start = 1'b0, i_vld = 1'b0, i_dec_err = 1'b0;
  logic        i_cu_cmd = 1'b0, i_cu_sync = 1'b0, i_cu_sync_stop = 1'b0, i_cu_sync_intr = 1'b0;
  logic        i_vpu_cmd = 1'b0;
  logic [1:0]  i_vpu_mask = '0, i_vpu_rdy = '0, i_vpu_busy = '0;
  logic [4:0]  i_vpu_op = '0;
  logic [2:0]  i_vpu_th = '0;
  logic [47:0] i_vpu_pl = '0;
  logic        o_rdy, o_stopped, o_err, o_intr;
  logic [1:0]  o_vpu_vld;
  logic [4:0]  o_vpu_op;
  logic [2:0]  o_vpu_th;
  logic [47:0] o_vpu_pl;
  logic [31:0] o_perf_cmds, o_perf_stall;

  int n_chk = 0;
  int n_err = 0;

  vxe_cu_cmd_dispatch #(.VPUS_NR(2)) dut (
    .clk(clk), .nrst(nrst), .i_start(i_start), .i_vld(i_vld), .o_rdy(o_rdy),
    .i_dec_err(i_dec_err), .i_cu_cmd(i_cu_cmd), .i_cu_sync(i_cu_sync),
    .i_cu_sync_stop(i_cu_sync_stop), .i_cu_sync_intr(i_cu_sync_intr),
    .i_vpu_cmd(i_vpu_cmd), .i_vpu_mask(i_vpu_mask), .i_vpu_op(i_vpu_op),
    .i_vpu_th(i_vpu_th), .i_vpu_pl(i_vpu_pl), .o_vpu_vld(o_vpu_vld),
    .i_vpu_rdy(i_vpu_rdy), .o_vpu_op(o_vpu_op), .o_vpu_th(o_vpu_th),
    .o_vpu_pl(o_vpu_pl), .i_vpu_busy(i_vpu_busy), .o_stopped(o_stopped),
    .o_err(o_err), .o_intr(o_intr), .o_perf_cmds(o_perf_cmds),
    .o_perf_stall(o_perf_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        st, vld, de, cu, sy, sp, it, vc;
    logic [1:0]  m;
    logic [4:0]  op;
    logic [47:0] pl;
    logic [1:0]  vr, bs;
    logic        erdy;
    logic [1:0]  evv;
    logic        estp, eerr, eintr;
    logic [4:0]  eop;
    logic [47:0] epl;
  } vec_t;

  vec_t tv[29];

  function automatic vec_t V(string nm, logic st, logic vld, logic de, logic cu,
                             logic sy, logic sp, logic it, logic vc, logic [1:0] m,
                             logic [4:0] op, logic [47:0] pl, logic [1:0] vr,
                             logic [1:0] bs, logic erdy, logic [1:0] evv, logic estp,
                             logic eerr, logic eintr, logic [4:0] eop, logic [47:0] epl);
    vec_t v;
    v.nm = nm; v.st = st; v.vld = vld; v.de = de; v.cu = cu; v.sy = sy; v.sp = sp;
    v.it = it; v.vc = vc; v.m = m; v.op = op; v.pl = pl; v.vr = vr; v.bs = bs;
    v.erdy = erdy; v.evv = evv; v.estp = estp; v.eerr = eerr; v.eintr = eintr;
    v.eop = eop; v.epl = epl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drive one vector just after a posedge, check just before the next one
  task automatic apply(input int i);
    vec_t v;
    v = tv[i];
    i_start = v.st; i_vld = v.vld; i_dec_err = v.de; i_cu_cmd = v.cu;
    i_cu_sync = v.sy; i_cu_sync_stop = v.sp; i_cu_sync_intr = v.it;
    i_vpu_cmd = v.vc; i_vpu_mask = v.m; i_vpu_op = v.op; i_vpu_th = v.op[2:0];
    i_vpu_pl = v.pl; i_vpu_rdy = v.vr; i_vpu_busy = v.bs;
    #3;
    chk($sformatf("v%0d %s rdy", i, v.nm), 64'(o_rdy), 64'(v.erdy));
    chk($sformatf("v%0d %s vld", i, v.nm), 64'(o_vpu_vld), 64'(v.evv));
    chk($sformatf("v%0d %s stopped", i, v.nm), 64'(o_stopped), 64'(v.estp));
    chk($sformatf("v%0d %s err", i, v.nm), 64'(o_err), 64'(v.eerr));
    chk($sformatf("v%0d %s intr", i, v.nm), 64'(o_intr), 64'(v.eintr));
    if (v.evv != 2'b00) begin
      chk($sformatf("v%0d %s op", i, v.nm), 64'(o_vpu_op), 64'(v.eop));
      chk($sformatf("v%0d %s th", i, v.nm), 64'(o_vpu_th), 64'(v.eop[2:0]));
      chk($sformatf("v%0d %s pl", i, v.nm), 64'(o_vpu_pl), 64'(v.epl));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    i_start = 0; i_vld = 0; i_dec_err = 0; i_cu_cmd = 0; i_cu_sync = 0;
    i_cu_sync_stop = 0; i_cu_sync_intr = 0; i_vpu_cmd = 0; i_vpu_mask = '0;
    i_vpu_op = '0; i_vpu_th = '0; i_vpu_pl = '0; i_vpu_rdy = '0; i_vpu_busy = '0;
  endtask

  initial begin
    logic [31:0] exp_c1, exp_s1;
`ifdef VXE_CU_DISP_PERF_EN
    exp_c1 = 32'd2; exp_s1 = 32'd8;
`else
    exp_c1 = 32'd0; exp_s1 = 32'd0;
`endif
    //            name       st v de cu sy sp it vc m      op     pl         vr     bs    rdy vv    stp er in eop    epl
    tv[0]  = V("start",      1,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 0,2'b00, 1,0,0, 5'h00,48'h0);
    tv[1]  = V("nop",        0,1,0, 1, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 1,2'b00, 0,0,0, 5'h00,48'h0);
    tv[2]  = V("idle",       0,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 1,2'b00, 0,0,0, 5'h00,48'h0);
    tv[3]  = V("uc_acc",     0,1,0, 0, 0, 0, 0, 1, 2'b10,5'h08,48'h1234,  2'b10,2'b00, 1,2'b00, 0,0,0, 5'h00,48'h0);
    tv[4]  = V("uc_disp",    0,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b10,2'b00, 0,2'b10, 0,0,0, 5'h08,48'h1234);
    tv[5]  = V("bc_acc",     0,1,0, 0, 0, 0, 0, 1, 2'b11,5'h03,48'hABCD,  2'b00,2'b00, 1,2'b00, 0,0,0, 5'h00,48'h0);
    tv[6]  = V("bc_d1",      0,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b01,2'b00, 0,2'b11, 0,0,0, 5'h03,48'hABCD);
    tv[7]  = V("bc_d2",      0,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 0,2'b10, 0,0,0, 5'h03,48'hABCD);
    tv[8]  = V("bc_d3",      0,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 0,2'b10, 0,0,0, 5'h03,48'hABCD);
    tv[9]  = V("bc_d4",      0,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b10,2'b00, 0,2'b10, 0,0,0, 5'h03,48'hABCD);
    tv[10] = V("sync_acc",   0,1,0, 1, 1, 1, 1, 0, 2'b00,5'h00,48'h0,     2'b00,2'b01, 1,2'b00, 0,0,0, 5'h00,48'h0);
    for (int i = 11; i <= 15; i++)
      tv[i] = V("sync_wait", 0,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b01, 0,2'b00, 0,0,0, 5'h00,48'h0);
    tv[16] = V("sync_done",  0,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 0,2'b00, 0,0,0, 5'h00,48'h0);
    tv[17] = V("intr",       0,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 0,2'b00, 1,0,1, 5'h00,48'h0);
    tv[18] = V("stop_hold",  0,1,0, 1, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 0,2'b00, 1,0,0, 5'h00,48'h0);
    tv[19] = V("restart",    1,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 0,2'b00, 1,0,0, 5'h00,48'h0);
    tv[20] = V("derr_acc",   0,1,1, 0, 0, 0, 0, 1, 2'b01,5'h05,48'h55,    2'b11,2'b00, 1,2'b00, 0,0,0, 5'h00,48'h0);
    tv[21] = V("err",        0,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b11,2'b00, 0,2'b00, 0,1,0, 5'h00,48'h0);
    tv[22] = V("err_start",  1,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 0,2'b00, 0,1,0, 5'h00,48'h0);
    tv[23] = V("err_clr",    0,1,0, 1, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 1,2'b00, 0,0,0, 5'h00,48'h0);
    tv[24] = V("mask0_acc",  0,1,0, 0, 0, 0, 0, 1, 2'b00,5'h1F,48'h77,    2'b11,2'b00, 1,2'b00, 0,0,0, 5'h00,48'h0);
    tv[25] = V("mask0_err",  1,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b11,2'b00, 0,2'b00, 0,1,0, 5'h00,48'h0);
    tv[26] = V("sync2_acc",  0,1,0, 1, 1, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 1,2'b00, 0,0,0, 5'h00,48'h0);
    tv[27] = V("sync2_done", 0,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 0,2'b00, 0,0,0, 5'h00,48'h0);
    tv[28] = V("sync2_run",  0,0,0, 0, 0, 0, 0, 0, 2'b00,5'h00,48'h0,     2'b00,2'b00, 1,2'b00, 0,0,0, 5'h00,48'h0);

    // reset state
    #12;
    chk("rst stopped", 64'(o_stopped), 64'd1);
    chk("rst rdy", 64'(o_rdy), 64'd0);
    chk("rst err", 64'(o_err), 64'd0);
    chk("rst intr", 64'(o_intr), 64'd0);
    chk("rst vld", 64'(o_vpu_vld), 64'd0);
    chk("rst op", 64'(o_vpu_op), 64'd0);
    chk("rst th", 64'(o_vpu_th), 64'd0);
    chk("rst pl", 64'(o_vpu_pl), 64'd0);
    chk("rst perf_cmds", 64'(o_perf_cmds), 64'd0);
    chk("rst perf_stall", 64'(o_perf_stall), 64'd0);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i <= 18; i++) apply(i);
    chk("perf_cmds after sync", 64'(o_perf_cmds), 64'(exp_c1));
    chk("perf_stall after sync", 64'(o_perf_stall), 64'(exp_s1));
    for (int i = 19; i <= 28; i++) apply(i);
    chk("perf_cmds cleared", 64'(o_perf_cmds), 64'd0);
    chk("perf_stall cleared", 64'(o_perf_stall), 64'd0);

    // async reset while VPU0 is still pending in DISP
    clr_inputs();
    i_vld = 1; i_vpu_cmd = 1; i_vpu_mask = 2'b01; i_vpu_op = 5'h11; i_vpu_pl = 48'h99;
    @(posedge clk);
    #1;
    clr_inputs();
    #3;
    chk("midrst pre vld", 64'(o_vpu_vld), 64'd1);
    nrst = 1'b0;
    #1;
    chk("midrst vld", 64'(o_vpu_vld), 64'd0);
    chk("midrst stopped", 64'(o_stopped), 64'd1);
    chk("midrst intr", 64'(o_intr), 64'd0);
    @(posedge clk);
    #2;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst stopped", 64'(o_stopped), 64'd1);
    chk("post rst rdy", 64'(o_rdy), 64'd0);
    chk("post rst vld", 64'(o_vpu_vld), 64'd0);
    i_start = 1;
    @(posedge clk);
    #1;
    i_start = 0;
    chk("post start rdy", 64'(o_rdy), 64'd1);
    chk("post start stopped", 64'(o_stopped), 64'd0);
    chk("post start vld", 64'(o_vpu_vld), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
